// File: rtl/sfu_pkg.sv
// Shared SFU lookup-ROM types and table selects, common to the arbiter and
// the requesting seed stages.
package sfu_pkg;

    localparam int SFU_ROM_AW = 10;
    localparam int SFU_ROM_DW = 16;

    typedef logic [SFU_ROM_AW-1:0] sfu_rom_addr_t;
    typedef logic [SFU_ROM_DW-1:0] sfu_rom_data_t;

    // Table region a requester addresses; the ROM map is owned by the requesters.
    typedef enum logic [1:0] {
        SFU_TBL_RECIP = 2'd0,
        SFU_TBL_RSQRT = 2'd1,
        SFU_TBL_LOG2  = 2'd2,
        SFU_TBL_EXP   = 2'd3
    } sfu_table_e;

endpackage

// File: rtl/sfu_lookup_arbiter_if.sv
// Single response slot of the lookup arbiter: valid/ready handshake carrying
// requester id, tag and the ROM word.
interface sfu_lookup_arbiter_if
    import sfu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic             resp_valid;
    logic             resp_ready;
    logic [ID_W-1:0]  resp_id;
    logic [TAG_W-1:0] resp_tag;
    sfu_rom_data_t    resp_data;

    modport master (
        output resp_valid,
        output resp_id,
        output resp_tag,
        output resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_id,
        input  resp_tag,
        input  resp_data,
        output resp_ready
    );

endinterface

// File: rtl/sfu_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant,
// wrapping modulo NUM_REQ.
module sfu_rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic               found_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_i) + k) % NUM_REQ);
            if (!found_o && req_valid_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/sfu_lookup_arbiter.sv
// Round-robin arbiter sharing one 1-cycle registered lookup ROM among NUM_REQ
// requesters; the ROM's hold-on-!rd_en output doubles as the response buffer.
module sfu_lookup_arbiter
    import sfu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*SFU_ROM_AW-1:0] req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    output sfu_rom_addr_t               rom_rd_addr,
    output logic                        rom_rd_en,
    input  sfu_rom_data_t               rom_rd_data,
    sfu_lookup_arbiter_if.master        resp
);

    localparam int ID_W = $clog2(NUM_REQ);

    sfu_rom_addr_t    addr_arr [NUM_REQ];
    logic [TAG_W-1:0] tag_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*SFU_ROM_AW +: SFU_ROM_AW];
        assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
    end

    logic             resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]  resp_id_q,    resp_id_d;
    logic [TAG_W-1:0] resp_tag_q,   resp_tag_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;

    logic             found;
    logic [ID_W-1:0]  pick_idx;
    logic             can_issue;
    logic             grant;

    sfu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .found_o      (found),
        .idx_o        (pick_idx)
    );

    // A new lookup may only launch when the slot is empty or drains this cycle,
    // otherwise it would overwrite the ROM word still awaiting acceptance.
    assign can_issue = !resp_valid_q || resp.resp_ready;
    assign grant     = found && can_issue && !reset;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    assign rom_rd_en   = grant;
    assign rom_rd_addr = found ? addr_arr[pick_idx] : '0;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_tag_d   = resp_tag_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            resp_valid_d = 1'b1;
            resp_id_d    = pick_idx;
            resp_tag_d   = tag_arr[pick_idx];
            last_grant_d = pick_idx;
        end else if (resp.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_tag_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_tag_q   <= resp_tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp.resp_valid = resp_valid_q;
    assign resp.resp_id    = resp_id_q;
    assign resp.resp_tag   = resp_tag_q;
    assign resp.resp_data  = rom_rd_data;

endmodule

// File: tb/tb_sfu_lookup_arbiter.sv
// Bench for sfu_lookup_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model and a registered ROM model.
module tb_sfu_lookup_arbiter;

    localparam int N     = 4;
    localparam int TAG_W = 4;
    localparam int ID_W  = $clog2(N);

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*10-1:0]    req_addr;
    logic [N*TAG_W-1:0] req_tag;
    logic [9:0]         rom_rd_addr;
    logic               rom_rd_en;
    logic [15:0]        rom_q;
    logic               resp_ready;

    int total = 0;
    int bad   = 0;

    sfu_lookup_arbiter_if #(.NUM_REQ(N), .TAG_W(TAG_W)) rif ();
    assign rif.resp_ready = resp_ready;

    sfu_lookup_arbiter #(.NUM_REQ(N), .TAG_W(TAG_W)) dut (
        .clock       (clk),
        .reset       (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_tag     (req_tag),
        .rom_rd_addr (rom_rd_addr),
        .rom_rd_en   (rom_rd_en),
        .rom_rd_data (rom_q),
        .resp        (rif)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romf(input logic [9:0] a);
        return 16'(a * 16'd57) ^ 16'hC3A5 ^ {a[5:0], a};
    endfunction

    // Registered ROM: output holds while rd_en is low, never cleared by reset.
    initial rom_q = 16'h0;
    always @(posedge clk) if (rom_rd_en) rom_q <= romf(rom_rd_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] addr_of(input int i);
        return req_addr[i*10 +: 10];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input int i);
        return req_tag[i*TAG_W +: TAG_W];
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        int          tag;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    bit   m_valid = 1'b0;
    int   m_last  = N - 1;
    int   wait_cnt [N];

    always @(negedge clk) begin
        bit   found;
        bit   grant;
        int   cand;
        exp_t e;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_valid[(m_last + k) % N]) begin
                found = 1'b1;
                cand  = (m_last + k) % N;
            end
        end
        grant = found && (!m_valid || resp_ready) && !rst;

        chk("req_ready", req_ready, grant ? (32'd1 << cand) : 32'd0);
        chk("rom_rd_en", rom_rd_en, grant);
        chk("rom_rd_addr", rom_rd_addr, found ? addr_of(cand) : 10'd0);
        chk("resp_valid", rif.resp_valid, m_valid);

        if (m_valid) begin
            if (q.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("resp_id", rif.resp_id, q[0].id);
                chk("resp_tag", rif.resp_tag, q[0].tag);
                chk("resp_data", rif.resp_data, q[0].data);
            end
        end

        if (rst) begin
            m_valid = 1'b0;
            m_last  = N - 1;
            q.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || (grant && i == cand)) begin
                    wait_cnt[i] = 0;
                end else if (grant) begin
                    wait_cnt[i]++;
                    chk("fair_wait", (wait_cnt[i] < N), 1);
                end
            end
            if (m_valid && resp_ready && q.size() != 0) void'(q.pop_front());
            if (grant) begin
                e.id   = cand;
                e.tag  = tag_of(cand);
                e.data = romf(addr_of(cand));
                q.push_back(e);
                m_valid = 1'b1;
                m_last  = cand;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [9:0] a, input logic [TAG_W-1:0] t);
        req_addr[i*10 +: 10]     = a;
        req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_addr   = '0;
        req_tag    = '0;
        resp_ready = 1'b0;
        step();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rom_rd_en", rom_rd_en, 0);
        chk("rst_resp_valid", rif.resp_valid, 0);
        chk("rst_resp_id", rif.resp_id, 0);
        chk("rst_resp_tag", rif.resp_tag, 0);

        // single request, latency one cycle
        step();
        rst        = 1'b0;
        req_valid  = 4'b0001;
        set_req(0, 10'h155, 4'd3);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_valid", rif.resp_valid, 1);
        chk("t1_id", rif.resp_id, 0);
        chk("t1_tag", rif.resp_tag, 3);
        chk("t1_data", rif.resp_data, romf(10'h155));

        // all requesters active: strict rotation
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 10'(16 * i + 7), 4'(i + 8));
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_order", req_ready, 32'd1 << (k % N));
            step();
        end

        // stall holds the slot and the ROM word
        do_reset();
        req_valid = 4'b0100;
        set_req(2, 10'h3FF, 4'd5);
        @(negedge clk);
        chk("st_grant2", req_ready, 4'b0100);
        step();
        req_valid  = 4'b1011;
        resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(0, 10'($urandom), 4'($urandom));
            set_req(3, 10'($urandom), 4'($urandom));
            @(negedge clk);
            chk("st_no_ready", req_ready, 0);
            chk("st_no_rden", rom_rd_en, 0);
            chk("st_data", rif.resp_data, romf(10'h3FF));
            chk("st_id", rif.resp_id, 2);
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("st_next3", req_ready, 4'b1000);

        // single active requester granted every cycle
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            set_req(1, 10'(k * 91), 4'(k));
            @(negedge clk);
            chk("solo_grant", req_ready, 4'b0010);
            step();
        end
        req_valid = '0;
        @(negedge clk);
        chk("solo_last_valid", rif.resp_valid, 1);
        chk("solo_last_id", rif.resp_id, 1);
        chk("solo_last_tag", rif.resp_tag, 9);

        // reset while a response is pending
        step();
        req_valid = 4'hF;
        @(negedge clk);
        chk("rs_pre_grant", req_ready, 4'b0100);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rs_ready_low", req_ready, 0);
        step();
        @(negedge clk);
        chk("rs_dropped", rif.resp_valid, 0);
        chk("rs_ready_low2", req_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_first0", req_ready, 4'b0001);

        // randomized traffic
        for (int c = 0; c < 10000; c++) begin
            step();
            rst        = ($urandom_range(0, 999) == 0);
            req_valid  = 4'($urandom);
            req_addr   = 40'({$urandom, $urandom});
            req_tag    = 16'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfu_lookup_arbiter.md
Name: sfu_lookup_arbiter

Overview:
- Shares one SFU lookup ROM among NUM_REQ requesters, for example the recip, rsqrt, log2 and exp seed stages of the SFU lanes.
- The ROM has a 10-bit address, 16-bit data and a 1-cycle registered read. Its output holds while rd_en is low.
- Requests are arbitrated round-robin. Each granted request is issued to the ROM, and the returned word is presented with its requester id and tag through a single response slot with valid/ready handshake.
- The ROM's hold-on-!rd_en property is the stall mechanism, so no data buffer is needed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 4, width of the opaque tag carried from request to response.
- ID_W, $clog2(NUM_REQ), width of the requester index (derived, not overridable).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit set.
- req_addr  in  NUM_REQ*10  packed ROM addresses; requester i is at bits [i*10+:10].
- req_tag  in  NUM_REQ*TAG_W  packed tags.
- rom_rd_addr  out  10  to ROM rd_addr.
- rom_rd_en  out  1  to ROM rd_en.
- rom_rd_data  in  16  from ROM rd_data.
- resp_valid  out  1  response slot holds valid data.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  ID_W  requester index of the response.
- resp_tag  out  TAG_W  tag of the response.
- resp_data  out  16  equals rom_rd_data (passthrough).

Behaviour:
- Reset values: resp_valid=0, resp_id=0, resp_tag=0, last_grant=NUM_REQ-1 (so requester 0 has first priority). req_ready=0 and rom_rd_en=0 while reset is high.
- can_issue = !resp_valid || resp_ready.
- Round-robin search starts at last_grant+1, modulo NUM_REQ. The first i with req_valid[i] is the candidate.
- grant = candidate found && can_issue && !reset. It is combinational in the same cycle.
- req_ready[candidate] = grant; every other bit is 0. Ready depends on valid; requesters must not derive valid from ready.
- rom_rd_en = grant.
- rom_rd_addr = req_addr of the candidate when a candidate exists, otherwise 0. The address is don't-care when rom_rd_en=0.
- On a grant edge: resp_valid<=1, resp_id<=candidate, resp_tag<=req_tag[candidate], last_grant<=candidate.
  - Latency: request accepted in cycle N; resp_valid and rom_rd_data valid in cycle N+1.
- Response consumed with no new grant: resp_valid<=0; resp_id and resp_tag hold.
- Stall (resp_valid && !resp_ready):
  - no grant is made, so rom_rd_en=0;
  - the ROM holds rd_data, so resp_data/id/tag stay stable until accepted;
  - last_grant is unchanged.
- Simultaneous consume and new grant: resp_ready and a grant in the same cycle give back-to-back responses, one per cycle at full throughput.
- Fairness:
  - a requester that holds valid is granted within NUM_REQ grants;
  - a single active requester is granted every cycle;
  - last_grant updates only on an actual grant.
- Request hold: an ungranted request's addr/tag may change freely. Once granted, the request is consumed that edge.
- Reset mid-operation: a pending response is dropped (resp_valid=0) and the pointer re-initialises. The ROM output register is not cleared, which is harmless because resp_valid=0.
- The module holds no storage for ROM data; its only state is resp_valid/id/tag and last_grant.

Decomposition:
- Package sfu_pkg holds:
  - SFU_ROM_AW=10 and SFU_ROM_DW=16;
  - typedef sfu_rom_addr_t (logic [9:0]) and sfu_rom_data_t (logic [15:0]);
  - an enum for table selects, for use by the requesters.
- One natural sub-module: sfu_rr_picker. It is combinational and maps req_valid plus last_grant to found and index, so it can be reused by other SFU arbiters.
- Top-level integration instantiates sfu_lookup_arbiter alongside the ROM instance; the ROM is not inside this block.

Test Plan:
- Reset, then req_valid=4'b0001, addr0=10'h155, tag0=3 -> req_ready=0001 the same cycle; next cycle resp_valid=1, resp_id=0, resp_tag=3, resp_data=rom[0x155].
- req_valid=4'b1111 held, resp_ready=1 -> grant order 0,1,2,3,0,…, one per cycle; responses are in the same order with matching tags.
- Grant to requester 2 (addr 0x3FF), then resp_ready=0 for 5 cycles with other valids high -> no req_ready and rom_rd_en=0 for all 5 cycles; resp_data stays rom[0x3FF]. After resp_ready=1, the next grant goes to requester 3 in that same cycle.
- Only requester 1 valid for 10 cycles with resp_ready=1 -> 10 consecutive grants to 1, 10 responses in cycles 2..11, id=1.
- Assert reset while resp_valid=1 -> next cycle resp_valid=0 and req_ready=0. After deassert with all valid, the first grant goes to requester 0.
- Random valid/addr/tag/resp_ready for 10k cycles against a scoreboard model -> every accepted request is answered exactly once, in order, with correct data, id and tag. No requester waits more than NUM_REQ grants.
